change_dispenser: RTL and testbench

Parametrised, sequential successor to the combinational-per-register coin split. A latched amount in cents is turned into a stream of quarters, dimes and nickels using greedy selection, one coin per valid/ready handshake. Per-coin counts and a completion/error status are reported per transaction. It sits between the vending control FSM, which issues `start`/`amount`, and the coin-release actuator, which drives `coin_ready`.

---
 rtl/change_dispenser.sv | 237 +++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
//
// Turns a latched amount in cents into a stream of quarters, dimes and
// nickels. Coins are chosen greedily and handed out one per coin_valid /
// coin_ready handshake. Per-coin counts and a done/err status are reported
// for each transaction.
//
// Optional feature macro: COIN_INV_EN adds a coin inventory. It provides
// three stock registers, loaded in IDLE, that limit which coins may be issued.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   start, amount           request and change owed (sampled in IDLE only)
//   coin_ready              actuator accepts the presented coin
//   coin_valid, coin_type   presented coin (00 none, 01 N, 10 D, 11 Q)
//   busy                    high in CHECK and DISP
//   done, err               one-cycle completion pulse and its abort flag
//   q_cnt, d_cnt, n_cnt     coins dispensed in the current/last transaction
//   stock_load, stock_q/d/n (COIN_INV_EN only) inventory load in IDLE
module change_dispenser #(
    parameter int AMT_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             coin_ready,
`ifdef COIN_INV_EN
    input  logic             stock_load,
    input  logic [CNT_W-1:0] stock_q,
    input  logic [CNT_W-1:0] stock_d,
    input  logic [CNT_W-1:0] stock_n,
`endif
    output logic             coin_valid,
    output logic [1:0]       coin_type,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] q_cnt,
    output logic [CNT_W-1:0] d_cnt,
    output logic [CNT_W-1:0] n_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DISP  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_N    = 2'b01;
    localparam logic [1:0] COIN_D    = 2'b10;
    localparam logic [1:0] COIN_Q    = 2'b11;

    localparam logic [AMT_W-1:0] VAL_N = AMT_W'(5);
    localparam logic [AMT_W-1:0] VAL_D = AMT_W'(10);
    localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(25);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
    logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
    logic [CNT_W-1:0] n_cnt_q, n_cnt_d;
    logic             err_q, err_d;

    logic             q_avail, d_avail, n_avail;
    logic [1:0]       cand;
    logic             sel_ok;
    logic [AMT_W-1:0] sel_val;

`ifdef COIN_INV_EN
    logic [CNT_W-1:0] inv_q_q, inv_q_d;
    logic [CNT_W-1:0] inv_d_q, inv_d_d;
    logic [CNT_W-1:0] inv_n_q, inv_n_d;

    assign q_avail = (inv_q_q != '0);
    assign d_avail = (inv_d_q != '0);
    assign n_avail = (inv_n_q != '0);
`else
    assign q_avail = 1'b1;
    assign d_avail = 1'b1;
    assign n_avail = 1'b1;
`endif

    // Greedy pick: the largest coin that fits the remainder and is in stock.
    // An out-of-stock coin is simply skipped. A coin whose count has hit the
    // limit is not skipped: that ends the transaction with an error, so
    // counts can never wrap.
    always_comb begin
        cand    = COIN_NONE;
        sel_ok  = 1'b0;
        sel_val = '0;
        if (rem_q >= VAL_Q && q_avail) begin
            cand = COIN_Q;
        end else if (rem_q >= VAL_D && d_avail) begin
            cand = COIN_D;
        end else if (rem_q >= VAL_N && n_avail) begin
            cand = COIN_N;
        end
        case (cand)
            COIN_Q: begin
                sel_ok  = (q_cnt_q != CNT_MAX);
                sel_val = VAL_Q;
            end
            COIN_D: begin
                sel_ok  = (d_cnt_q != CNT_MAX);
                sel_val = VAL_D;
            end
            COIN_N: begin
                sel_ok  = (n_cnt_q != CNT_MAX);
                sel_val = VAL_N;
            end
            default: begin
                sel_ok  = 1'b0;
                sel_val = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        q_cnt_d = q_cnt_q;
        d_cnt_d = d_cnt_q;
        n_cnt_d = n_cnt_q;
        err_d   = err_q;
`ifdef COIN_INV_EN
        inv_q_d = inv_q_q;
        inv_d_d = inv_d_q;
        inv_n_d = inv_n_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef COIN_INV_EN
                if (stock_load) begin
                    inv_q_d = stock_q;
                    inv_d_d = stock_d;
                    inv_n_d = stock_n;
                end
`endif
                if (start) begin
                    rem_d   = amount;
                    q_cnt_d = '0;
                    d_cnt_d = '0;
                    n_cnt_d = '0;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((rem_q % VAL_N) != '0) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (rem_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_DISP;
                end
            end
            S_DISP: begin
                if (!sel_ok) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (coin_ready) begin
                    rem_d = rem_q - sel_val;
                    case (cand)
                        COIN_Q: begin
                            q_cnt_d = q_cnt_q + CNT_ONE;
`ifdef COIN_INV_EN
                            inv_q_d = inv_q_q - CNT_ONE;
`endif
                        end
                        COIN_D: begin
                            d_cnt_d = d_cnt_q + CNT_ONE;
`ifdef COIN_INV_EN
                            inv_d_d = inv_d_q - CNT_ONE;
`endif
                        end
                        default: begin
                            n_cnt_d = n_cnt_q + CNT_ONE;
`ifdef COIN_INV_EN
                            inv_n_d = inv_n_q - CNT_ONE;
`endif
                        end
                    endcase
                    if (rem_d == '0) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            q_cnt_q <= '0;
            d_cnt_q <= '0;
            n_cnt_q <= '0;
            err_q   <= 1'b0;
`ifdef COIN_INV_EN
            inv_q_q <= '0;
            inv_d_q <= '0;
            inv_n_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            q_cnt_q <= q_cnt_d;
            d_cnt_q <= d_cnt_d;
            n_cnt_q <= n_cnt_d;
            err_q   <= err_d;
`ifdef COIN_INV_EN
            inv_q_q <= inv_q_d;
            inv_d_q <= inv_d_d;
            inv_n_q <= inv_n_d;
`endif
        end
    end

    assign coin_valid = (state_q == S_DISP) && sel_ok;
    assign coin_type  = coin_valid ? cand : COIN_NONE;
    assign busy       = (state_q == S_CHECK) || (state_q == S_DISP);
    assign done       = (state_q == S_FIN);
    assign err        = (state_q == S_FIN) && err_q;
    assign q_cnt      = q_cnt_q;
    assign d_cnt      = d_cnt_q;
    assign n_cnt      = n_cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser (AMT_W=10, CNT_W=4). The table drives
// transactions with coin_ready tied high. Hand-written sequences cover the
// stalled handshake, reset in mid-transaction and, with COIN_INV_EN, stock
// exhaustion.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] amount;
    logic       coin_ready;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] q_cnt, d_cnt, n_cnt;
`ifdef COIN_INV_EN
    logic       stock_load;
    logic [3:0] stock_q, stock_d, stock_n;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    change_dispenser #(.AMT_W(10), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .amount     (amount),
        .coin_ready (coin_ready),
`ifdef COIN_INV_EN
        .stock_load (stock_load),
        .stock_q    (stock_q),
        .stock_d    (stock_d),
        .stock_n    (stock_n),
`endif
        .coin_valid (coin_valid),
        .coin_type  (coin_type),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .q_cnt      (q_cnt),
        .d_cnt      (d_cnt),
        .n_cnt      (n_cnt)
    );

    // One directed transaction: coins[2i+1:2i] is the i-th expected coin.
    typedef struct {
        logic [9:0]  amt;
        int          ncoins;
        logic [31:0] coins;
        int          done_idx;
        logic        err;
        int          q, d, n;
        logic        inv_skip;  // expectation assumes unlimited stock
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string nm, input int q, input int d, input int n);
        check({nm, ".q_cnt"}, 32'(q_cnt), 32'(q));
        check({nm, ".d_cnt"}, 32'(d_cnt), 32'(d));
        check({nm, ".n_cnt"}, 32'(n_cnt), 32'(n));
    endtask

    // Observation k is taken 1 time unit after the k-th edge following the
    // edge that samples start (k=0 is the CHECK cycle).
    task automatic run_txn(input string nm, input logic [9:0] amt, input int ncoins,
                           input logic [31:0] coins, input int done_idx, input logic e_err,
                           input int q, input int d, input int n);
        int f0;
        logic ev;
        logic [1:0] et;
        f0 = failures;
        start = 1'b1;
        amount = amt;
        coin_ready = 1'b1;
        for (int k = 0; k <= done_idx; k++) begin
            step();
            if (k == 0) begin
                start = 1'b0;
`ifdef COIN_INV_EN
                stock_load = 1'b0;
`endif
            end
            ev = (k >= 1) && (k <= ncoins);
            et = ev ? coins[2*(k-1) +: 2] : 2'b00;
            check($sformatf("%s.valid@%0d", nm, k), 32'(coin_valid), 32'(ev));
            check($sformatf("%s.type@%0d", nm, k), 32'(coin_type), 32'(et));
            check($sformatf("%s.done@%0d", nm, k), 32'(done), 32'(k == done_idx));
            check($sformatf("%s.busy@%0d", nm, k), 32'(busy), 32'(k != done_idx));
            if (k == done_idx) begin
                check({nm, ".err"}, 32'(err), 32'(e_err));
            end
        end
        check_counts(nm, q, d, n);
        step();
        check({nm, ".idle_done"}, 32'(done), 32'd0);
        check_counts({nm, ".held"}, q, d, n);
        $display("txn %s amount=%0d q=%0d d=%0d n=%0d err_exp=%0d %s", nm, amt,
                 q_cnt, d_cnt, n_cnt, e_err, (failures == f0) ? "ok" : "bad");
    endtask

    initial begin
        vecs[0]  = '{10'd65,   4,  32'h0000006F, 5,  1'b0, 2,  1, 1, 1'b0};
        vecs[1]  = '{10'd0,    0,  32'h00000000, 1,  1'b0, 0,  0, 0, 1'b0};
        vecs[2]  = '{10'd37,   0,  32'h00000000, 1,  1'b1, 0,  0, 0, 1'b0};
        vecs[3]  = '{10'd5,    1,  32'h00000001, 2,  1'b0, 0,  0, 1, 1'b0};
        vecs[4]  = '{10'd30,   2,  32'h00000007, 3,  1'b0, 1,  0, 1, 1'b0};
        vecs[5]  = '{10'd40,   3,  32'h0000001B, 4,  1'b0, 1,  1, 1, 1'b0};
        vecs[6]  = '{10'd255,  11, 32'h001FFFFF, 12, 1'b0, 10, 0, 1, 1'b0};
        vecs[7]  = '{10'd20,   2,  32'h0000000A, 3,  1'b0, 0,  2, 0, 1'b0};
        vecs[8]  = '{10'd3,    0,  32'h00000000, 1,  1'b1, 0,  0, 0, 1'b0};
        vecs[9]  = '{10'd400,  15, 32'h3FFFFFFF, 17, 1'b1, 15, 0, 0, 1'b1};
        vecs[10] = '{10'd1023, 0,  32'h00000000, 1,  1'b1, 0,  0, 0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        amount = '0;
        coin_ready = 1'b0;
`ifdef COIN_INV_EN
        stock_load = 1'b0;
        stock_q = '0;
        stock_d = '0;
        stock_n = '0;
`endif
        step();
        step();
        check("rst.valid", 32'(coin_valid), 32'd0);
        check("rst.type", 32'(coin_type), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check_counts("rst", 0, 0, 0);
        reset = 1'b0;
        step();

        // Table: greedy split with coin_ready tied high.
        for (int i = 0; i < 11; i++) begin
`ifdef COIN_INV_EN
            if (vecs[i].inv_skip) continue;
            stock_load = 1'b1;
            stock_q = 4'd15;
            stock_d = 4'd15;
            stock_n = 4'd15;
`endif
            run_txn($sformatf("amt%0d", vecs[i].amt), vecs[i].amt, vecs[i].ncoins,
                    vecs[i].coins, vecs[i].done_idx, vecs[i].err,
                    vecs[i].q, vecs[i].d, vecs[i].n);
        end

        // Stalled first coin, plus start pulses while busy that must be ignored.
`ifdef COIN_INV_EN
        stock_load = 1'b1;
        stock_q = 4'd15;
        stock_d = 4'd15;
        stock_n = 4'd15;
`endif
        start = 1'b1;
        amount = 10'd40;
        coin_ready = 1'b0;
        step();
`ifdef COIN_INV_EN
        stock_load = 1'b0;
`endif
        check("stall.busy@0", 32'(busy), 32'd1);
        amount = 10'd65;
        for (int k = 1; k <= 3; k++) begin
            step();
            start = 1'b0;
            check($sformatf("stall.valid@%0d", k), 32'(coin_valid), 32'd1);
            check($sformatf("stall.type@%0d", k), 32'(coin_type), 32'd3);
            check($sformatf("stall.q_cnt@%0d", k), 32'(q_cnt), 32'd0);
        end
        step();
        coin_ready = 1'b1;
        start = 1'b1;
        check("stall.type@4", 32'(coin_type), 32'd3);
        step();
        start = 1'b0;
        check("stall.type@5", 32'(coin_type), 32'd2);
        step();
        check("stall.type@6", 32'(coin_type), 32'd1);
        step();
        check("stall.done@7", 32'(done), 32'd1);
        check("stall.err@7", 32'(err), 32'd0);
        check_counts("stall", 1, 1, 1);
        step();
        check("stall.no_restart", 32'(busy), 32'd0);
        $display("txn stall40 q=%0d d=%0d n=%0d", q_cnt, d_cnt, n_cnt);

        // Reset in DISP after one transfer aborts without a done pulse.
`ifdef COIN_INV_EN
        stock_load = 1'b1;
        stock_q = 4'd15;
        stock_d = 4'd15;
        stock_n = 4'd15;
`endif
        start = 1'b1;
        amount = 10'd65;
        coin_ready = 1'b1;
        step();
        start = 1'b0;
`ifdef COIN_INV_EN
        stock_load = 1'b0;
`endif
        step();
        step();
        check("abort.pre_q_cnt", 32'(q_cnt), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort.valid", 32'(coin_valid), 32'd0);
        check("abort.type", 32'(coin_type), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.err", 32'(err), 32'd0);
        check_counts("abort", 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("abort.nodone@%0d", k), 32'(done), 32'd0);
        end
        $display("txn abort65 busy=%0d done=%0d", busy, done);
`ifdef COIN_INV_EN
        stock_load = 1'b1;
        stock_q = 4'd15;
        stock_d = 4'd15;
        stock_n = 4'd15;
`endif
        run_txn("after_reset10", 10'd10, 1, 32'h2, 2, 1'b0, 0, 1, 0);

`ifdef COIN_INV_EN
        // Stock Q=1 D=3 N=0: greedy strands 5 cents.
        stock_load = 1'b1;
        stock_q = 4'd1;
        stock_d = 4'd3;
        stock_n = 4'd0;
        run_txn("inv30", 10'd30, 1, 32'h3, 3, 1'b1, 1, 0, 0);
        stock_load = 1'b1;
        run_txn("inv20", 10'd20, 2, 32'hA, 3, 1'b0, 0, 2, 0);
        // No reload: one dime left from the previous transaction.
        stock_load = 1'b0;
        run_txn("inv20_rest", 10'd20, 1, 32'h2, 3, 1'b1, 0, 1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
